// File: rtl/synth_audio_pkg.sv
// Shared audio constants and types for the synth voice path (wave generators,
// mixer and the I2S transmitter).
package synth_audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam int I2S_SLOT_W  = 32;
    localparam int I2S_CLK_DIV = 8;

endpackage

// File: rtl/i2s_sample_transmitter_if.sv
// Sample hand-off and I2S line bundle between the mixer and the DAC transmitter.
// The master side feeds samples; the slave side is the transmitter.
interface i2s_sample_transmitter_if
    import synth_audio_pkg::*;
#(
    parameter int SAMPLE_W = synth_audio_pkg::SAMPLE_W
);

    logic signed [SAMPLE_W-1:0] sample_l;
    logic signed [SAMPLE_W-1:0] sample_r;
    logic                       sample_load;
    logic                       bclk;
    logic                       lrck;
    logic                       dacdat;

    modport master (
        output sample_l,
        output sample_r,
        input  sample_load,
        input  bclk,
        input  lrck,
        input  dacdat
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        output sample_load,
        output bclk,
        output lrck,
        output dacdat
    );

endinterface

// File: rtl/i2s_clock_divider.sv
// Bit-clock generator: divides clk down to BCLK and flags each BCLK falling
// edge with a one-cycle shift_stb, coincident with bclk going low.
module i2s_clock_divider
    import synth_audio_pkg::*;
#(
    parameter int CLK_DIV = I2S_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic shift_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             bclk_q;
    logic             bclk_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == CNT_LAST);
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d    = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk = bclk_q;
    // Falling edge is the wrap while bclk is still high; downstream registers
    // update on the same clk edge that drives bclk low.
    assign shift_stb = wrap & bclk_q;

endmodule

// File: rtl/i2s_sample_transmitter.sv
// I2S transmitter toward the codec DAC: captures one stereo pair per frame and
// shifts it out MSB-first, one BCLK after each lrck edge, zero padded.
// Build option I2S_TX_MONO_EN: right shadow captures sample_l, sample_r ignored.
module i2s_sample_transmitter
    import synth_audio_pkg::*;
#(
    parameter int CLK_DIV  = I2S_CLK_DIV,
    parameter int SAMPLE_W = synth_audio_pkg::SAMPLE_W,
    parameter int SLOT_W   = I2S_SLOT_W
) (
    input logic                     clk,
    input logic                     reset,
    i2s_sample_transmitter_if.slave bus
);

    localparam int FRAME_LEN = 2 * SLOT_W;
    localparam int B_W       = $clog2(FRAME_LEN);
    localparam int IDX_W     = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    localparam logic [B_W-1:0] B_LAST = B_W'(FRAME_LEN - 1);
    localparam logic [B_W-1:0] B_SLOT = B_W'(SLOT_W);
    localparam logic [B_W-1:0] B_SAMP = B_W'(SAMPLE_W);

    if (SAMPLE_W > SLOT_W - 1) begin : g_bad_sample_w
        $error("i2s_sample_transmitter: SAMPLE_W must be <= SLOT_W-1");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("i2s_sample_transmitter: CLK_DIV must be >= 2");
    end

    logic                       shift_stb;
    logic                       bclk;

    logic [B_W-1:0]             b_q, b_d;
    logic                       lrck_q, lrck_d;
    logic                       dacdat_q, dacdat_d;
    logic                       load_pend_q, load_pend_d;
    logic                       sample_load_q, sample_load_d;
    logic signed [SAMPLE_W-1:0] shadow_l_q, shadow_l_d;
    logic signed [SAMPLE_W-1:0] shadow_r_q, shadow_r_d;

    logic [B_W-1:0]             b_next;
    logic                       right_slot;
    logic [B_W-1:0]             slot_pos;
    logic [B_W-1:0]             bit_sel;
    logic                       data_bit;

    i2s_clock_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .shift_stb (shift_stb)
    );

    always_comb begin
        b_next     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
        right_slot = (b_next >= B_SLOT);
        slot_pos   = right_slot ? b_next - B_SLOT : b_next;
        // Slot position 1 carries the MSB, position SAMPLE_W the LSB.
        bit_sel    = B_SAMP - slot_pos;
        data_bit   = right_slot ? shadow_r_q[IDX_W'(bit_sel)] : shadow_l_q[IDX_W'(bit_sel)];

        b_d           = b_q;
        lrck_d        = lrck_q;
        dacdat_d      = dacdat_q;
        shadow_l_d    = shadow_l_q;
        shadow_r_d    = shadow_r_q;
        load_pend_d   = 1'b0;
        sample_load_d = load_pend_q;

        if (shift_stb) begin
            b_d      = b_next;
            lrck_d   = right_slot;
            dacdat_d = ((slot_pos != '0) && (slot_pos <= B_SAMP)) ? data_bit : 1'b0;
            if (b_next == '0) begin
                shadow_l_d  = bus.sample_l;
`ifdef I2S_TX_MONO_EN
                shadow_r_d  = bus.sample_l;
`else
                shadow_r_d  = bus.sample_r;
`endif
                load_pend_d = 1'b1;
            end
        end
    end

    // Reset parks b on the last position so the first shift event captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q           <= B_LAST;
            lrck_q        <= 1'b0;
            dacdat_q      <= 1'b0;
            load_pend_q   <= 1'b0;
            sample_load_q <= 1'b0;
            shadow_l_q    <= '0;
            shadow_r_q    <= '0;
        end else begin
            b_q           <= b_d;
            lrck_q        <= lrck_d;
            dacdat_q      <= dacdat_d;
            load_pend_q   <= load_pend_d;
            sample_load_q <= sample_load_d;
            shadow_l_q    <= shadow_l_d;
            shadow_r_q    <= shadow_r_d;
        end
    end

    assign bus.bclk        = bclk;
    assign bus.lrck        = lrck_q;
    assign bus.dacdat      = dacdat_q;
    assign bus.sample_load = sample_load_q;

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// Bench for i2s_sample_transmitter: default instance plus a CLK_DIV=2/SLOT_W=25
// instance, frames compared against a stream-level model of the I2S layout.
`timescale 1ns/1ps
module tb_i2s_sample_transmitter;
    import synth_audio_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2s_sample_transmitter_if #(.SAMPLE_W(24)) bus1 ();
    i2s_sample_transmitter_if #(.SAMPLE_W(24)) bus2 ();

    i2s_sample_transmitter #(.CLK_DIV(8), .SAMPLE_W(24), .SLOT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    i2s_sample_transmitter #(.CLK_DIV(2), .SAMPLE_W(24), .SLOT_W(25)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_bclk_period = 0;
    int t_load = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic bclk_of(input int d);
        return (d == 0) ? bus1.bclk : bus2.bclk;
    endfunction
    function automatic logic lrck_of(input int d);
        return (d == 0) ? bus1.lrck : bus2.lrck;
    endfunction
    function automatic logic dat_of(input int d);
        return (d == 0) ? bus1.dacdat : bus2.dacdat;
    endfunction
    function automatic logic load_of(input int d);
        return (d == 0) ? bus1.sample_load : bus2.sample_load;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected frame as a bit stream: each slot is one 0, the sample MSB-first,
    // then zero fill to the slot width; lrck low for the left slot, high for right.
    task automatic exp_frame(input logic [23:0] l, input logic [23:0] r, input int slot,
                             output logic [127:0] dat, output logic [127:0] lr);
        logic [23:0] r_eff;
`ifdef I2S_TX_MONO_EN
        r_eff = l;
`else
        r_eff = r;
`endif
        dat = (128'(l) << (slot - 25));
        dat = (dat << slot) | (128'(r_eff) << (slot - 25));
        lr  = (128'(1) << slot) - 128'(1);
    endtask

    task automatic wait_load(input int d, input string tag);
        int limit;
        int n;
        limit = (d == 0) ? 1100 : 220;
        n = 0;
        while (!load_of(d) && n < limit) begin
            tick();
            n++;
        end
        if (!load_of(d)) check({tag, "_load_timeout"}, 128'(0), 128'(1));
        t_load = cyc;
    endtask

    // Records dacdat/lrck at each bclk rising edge, newest bit in the LSB.
    task automatic collect(input int d, input int n, output logic [127:0] dat, output logic [127:0] lr);
        logic prev;
        int got;
        int budget;
        int since;
        prev = bclk_of(d);
        got = 0;
        since = 0;
        budget = n * ((d == 0) ? 16 : 4) + 40;
        dat = '0;
        lr = '0;
        while (got < n && budget > 0) begin
            tick();
            budget--;
            since++;
            if (bclk_of(d) && !prev) begin
                dat = {dat[126:0], dat_of(d)};
                lr  = {lr[126:0], lrck_of(d)};
                got++;
                last_bclk_period = since;
                since = 0;
            end
            prev = bclk_of(d);
        end
        if (got < n) check("collect_timeout", 128'(got), 128'(n));
    endtask

    task automatic startup(input string tag);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("%s_bclk_%0d", tag, k), 128'(bus1.bclk), 128'((k >= 8) && (k < 16)));
            check($sformatf("%s_load_%0d", tag, k), 128'(bus1.sample_load), 128'(k == 17));
            check($sformatf("%s_lr_dat_%0d", tag, k), 128'({bus1.lrck, bus1.dacdat}), 128'(0));
        end
    endtask

    task automatic frame(input string tag, input bit do_wait,
                         input logic [23:0] cap_l, input logic [23:0] cap_r,
                         input logic [23:0] nxt_l, input logic [23:0] nxt_r);
        logic [127:0] gd, gl, ed, el;
        if (do_wait) wait_load(0, tag);
        bus1.sample_l = nxt_l;
        bus1.sample_r = nxt_r;
        collect(0, 64, gd, gl);
        exp_frame(cap_l, cap_r, 32, ed, el);
        check({tag, "_dat"}, gd, ed);
        check({tag, "_lrck"}, gl, el);
    endtask

    logic [127:0] gd, gl, g2d, g2l, ed, el;
    sample_t ra, rb, rl1, rr1, rl2, rr2, s2l, s2r, n2l, n2r;

    initial begin
        ra  = sample_t'($urandom);
        rb  = sample_t'($urandom);
        rl1 = sample_t'($urandom);
        rr1 = sample_t'($urandom);
        rl2 = sample_t'($urandom);
        rr2 = sample_t'($urandom);
        s2l = sample_t'($urandom);
        s2r = sample_t'($urandom);
        n2l = sample_t'($urandom);
        n2r = sample_t'($urandom);

        bus1.sample_l = 24'hA5A5A5;
        bus1.sample_r = 24'h5A5A5A;
        bus2.sample_l = s2l;
        bus2.sample_r = s2r;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_bclk", 128'(bus1.bclk), 128'(0));
        check("rst_lrck", 128'(bus1.lrck), 128'(0));
        check("rst_dacdat", 128'(bus1.dacdat), 128'(0));
        check("rst_load", 128'(bus1.sample_load), 128'(0));
        check("rst_small_outs", 128'({bus2.bclk, bus2.lrck, bus2.dacdat, bus2.sample_load}), 128'(0));

        reset = 1'b0;
        cyc = 0;
        startup("por");

        frame("f0", 1'b0, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A);
        check("bclk_period", 128'(last_bclk_period), 128'(16));
        frame("f1", 1'b1, 24'hA5A5A5, 24'h5A5A5A, 24'h000001, ra);
        check("load_at_1041", 128'(t_load), 128'(1041));

        // Left sample changes mid-left-slot; this frame must keep the captured value.
        wait_load(0, "f2");
        check("load_at_2065", 128'(t_load), 128'(2065));
        collect(0, 10, gd, gl);
        bus1.sample_l = 24'h800000;
        bus1.sample_r = rb;
        collect(0, 54, g2d, g2l);
        gd = (gd << 54) | g2d;
        gl = (gl << 54) | g2l;
        exp_frame(24'h000001, ra, 32, ed, el);
        check("f2_dat", gd, ed);
        check("f2_lrck", gl, el);

        frame("f3", 1'b1, 24'h800000, rb, 24'h123456, 24'hFFFFFF);
        frame("f4", 1'b1, 24'h123456, 24'hFFFFFF, rl1, rr1);
        frame("f5", 1'b1, rl1, rr1, rl2, rr2);

        // Reset pulse at b=40 abandons the frame and restarts from the top.
        wait_load(0, "f6");
        collect(0, 41, gd, gl);
        reset = 1'b1;
        tick();
        check("midrst_bclk", 128'(bus1.bclk), 128'(0));
        check("midrst_lrck", 128'(bus1.lrck), 128'(0));
        check("midrst_dacdat", 128'(bus1.dacdat), 128'(0));
        check("midrst_load", 128'(bus1.sample_load), 128'(0));
        reset = 1'b0;
        startup("restart");
        frame("f7", 1'b0, rl2, rr2, rl2, rr2);

        // Small configuration: 4-clk BCLK, 50-bit frame, no padding after LSB.
        wait_load(1, "s0");
        ed = 128'(t_load);
        bus2.sample_l = n2l;
        bus2.sample_r = n2r;
        collect(1, 50, gd, gl);
        exp_frame(s2l, s2r, 25, g2d, g2l);
        check("s0_dat", gd, g2d);
        check("s0_lrck", gl, g2l);
        check("s_bclk_period", 128'(last_bclk_period), 128'(4));
        wait_load(1, "s1");
        check("s_frame_len", 128'(t_load) - ed, 128'(200));
        collect(1, 50, gd, gl);
        exp_frame(n2l, n2r, 25, g2d, g2l);
        check("s1_dat", gd, g2d);
        check("s1_lrck", gl, g2l);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_sample_transmitter.md
# i2s_sample_transmitter

Serialises the synth's 24-bit mixed audio samples onto an I2S link toward the board audio codec DAC, and generates the bit clock and word-select signals. It sits at the output end of the voice path, after the wave generators and mixer. It latches one stereo sample pair per frame and pulses a load strobe so upstream logic knows when its value has been consumed.

## Interface
- `CLK_DIV`, default 8: clk cycles per BCLK half-period; must be ≥ 2.
- `SAMPLE_W`, default 24: sample width; must be ≤ `SLOT_W`-1, enforced by an elaboration check.
- `SLOT_W`, default 32: BCLK periods per channel slot.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `sample_l`  in  SAMPLE_W  left sample, two's complement; captured only at frame start.
- `sample_r`  in  SAMPLE_W  right sample, two's complement; captured only at frame start.
- `sample_load`  out  1  one-clk pulse, the cycle after a pair is captured.
- `bclk`  out  1  I2S bit clock.
- `lrck`  out  1  word select: 0 = left, 1 = right.
- `dacdat`  out  1  serial data, MSB first.

## Operation
- `div_cnt` counts 0..CLK_DIV-1 and wraps. `bclk` toggles in the cycle `div_cnt` wraps.
- A BCLK falling edge (`bclk` 1→0) is the shift event. All of `lrck`, `dacdat`, frame position and capture update only on shift events.
- Frame position `b` runs 0..2*SLOT_W-1 and wraps, incrementing on each shift event. Slot position is `p = b mod SLOT_W`.
- `lrck` = 0 for b < SLOT_W, 1 otherwise. It changes on the shift event where b becomes 0 or SLOT_W.
- `dacdat` for 1 ≤ p ≤ SAMPLE_W carries bit (SAMPLE_W-p) of the current channel's shadow register. For p = 0 and p > SAMPLE_W, `dacdat` = 0. This gives standard I2S: MSB appears one BCLK after the `lrck` edge, with zero padding.
- Capture happens on the shift event where b wraps to 0:
  - `sample_l` and `sample_r` load into shadow registers;
  - `sample_load` = 1 on the next clk cycle only.
- Inputs changing at any other time have no effect on the current frame.
- Reset state:
  - `div_cnt` = 0, `bclk` = 0, `lrck` = 0, `dacdat` = 0, `sample_load` = 0;
  - shadows = 0, b = 2*SLOT_W-1, so the first shift event starts frame 0 with a capture.
- Reset asserted mid-frame: all outputs return to reset values on the next clk edge. The partial frame is abandoned and no `sample_load` is issued for it.

## Timing
- BCLK period = 2*CLK_DIV clk. Frame = 2*SLOT_W*2*CLK_DIV clk (1024 at defaults; 48.8 kHz from a 50 MHz clk).
- After reset deassertion, at defaults:
  - `bclk` first rises 8 clk later and first falls 16 clk later (first capture);
  - `sample_load` is high in the following cycle;
  - `sample_load` then repeats every 1024 clk.
- `dacdat` and `lrck` change only coincident with `bclk` falling. Both are stable across each `bclk` rising edge, which is where the codec samples.
- Latency from capture to the left MSB on `dacdat` is 1 BCLK period. Right MSB follows at SLOT_W+1 BCLK periods.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `I2S_TX_MONO_EN` defined: `sample_r` is ignored and the right shadow captures `sample_l`. Both slots carry identical data.
- Undefined: the design is independent stereo as described above.

## Structure
- Package `synth_audio_pkg` holds:
  - `SAMPLE_W` (24);
  - typedef `sample_t` (logic signed [SAMPLE_W-1:0]);
  - I2S constants `I2S_SLOT_W` and `I2S_CLK_DIV`, shared with the wave generators and mixer.
- One sub-module, `i2s_clock_divider`. It owns `div_cnt` and `bclk`, and outputs a one-cycle `shift_stb` on each falling edge.
- The top level holds the frame counter, shadow registers, `lrck`/`dacdat` mux and `sample_load`.

## Test plan
1. Reset with defaults: all outputs 0. `bclk` rises at clk 8 and falls at clk 16. `sample_load` pulses at clk 17, 1041 and 2065 with exactly 1024-clk spacing.
2. `sample_l`=24'hA5A5A5, `sample_r`=24'h5A5A5A; sample `dacdat` on `bclk` rising edges. Required per frame:
   - left slot: one 0, then A5A5A5 MSB-first, then seven 0s;
   - right slot: `lrck`=1, same layout with 5A5A5A.
3. Change `sample_l` from 24'h000001 to 24'h800000 at b=10 (mid-left-slot): the current frame still sends 000001; the next frame sends 800000 (single 1 then 23 zeros).
4. Assert reset for 1 cycle at b=40: next cycle `bclk`=`lrck`=`dacdat`=0. The frame restarts with the same 16-clk first-capture timing; no stray `sample_load`.
5. `I2S_TX_MONO_EN` defined, `sample_l`=24'h123456, `sample_r`=24'hFFFFFF: both slots carry 123456.
6. `CLK_DIV`=2, `SLOT_W`=25, `SAMPLE_W`=24: BCLK period is 4 clk, frame is 200 clk, and there is no padding bit after the LSB.
